// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin EXU/LSU share of the GPR write port plus a per-register pending scoreboard
module gpr_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   qa,
  input  logic [AW-1:0]   qb,
  output logic            busy_a,
  output logic            busy_b,
  output logic            RegWr,
  output logic [AW-1:0]   Rw,
  output logic [XLEN-1:0] busW,
  output logic [AW:0]     pending_cnt
);
  localparam int NR = 2**AW;
  logic            last_q, last_d;
  logic [NR-1:0]   pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   rw_q, rw_d;
  logic [XLEN-1:0] busw_q, busw_d;
  logic            g0, g1, acc, wen, set;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  always_comb begin
    g0 = req0_valid && (!req1_valid || last_q);
    g1 = req1_valid && (!req0_valid || !last_q);
    acc = g0 || g1;
    w_rd = g0 ? req0_rd : req1_rd;
    w_data = g0 ? req0_data : req1_data;
    wen = acc && w_rd != '0;
    issue_ready = issue_rd == '0 || !pend_q[issue_rd] || (wen && w_rd == issue_rd);
    set = issue_valid && issue_ready && issue_rd != '0;
    last_d = acc ? g1 : last_q;
    wr_d = wen;
    rw_d = wen ? w_rd : rw_q;
    busw_d = wen ? w_data : busw_q;
    pend_d = '0;
    cnt_d = '0;
    // a same-cycle set beats the clear: the newer issue owns the register
    for (int i = 1; i < NR; i++) begin
      pend_d[i] = (pend_q[i] && !(wen && w_rd == AW'(i))) || (set && issue_rd == AW'(i));
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      pend_q <= '0;
      cnt_q  <= '0;
      wr_q   <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
    end else begin
      last_q <= last_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rw_q   <= rw_d;
      busw_q <= busw_d;
    end
  end
  assign req0_ready  = g0;
  assign req1_ready  = g1;
  assign busy_a      = pend_q[qa];
  assign busy_b      = pend_q[qb];
  assign RegWr       = wr_q;
  assign Rw          = rw_q;
  assign busW        = busw_q;
  assign pending_cnt = cnt_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed scenario bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, issue_valid = 0;
  logic [AW-1:0] req0_rd = '0, req1_rd = '0, issue_rd = '0, qa = '0, qb = '0;
  logic [XLEN-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, issue_ready, busy_a, busy_b, RegWr;
  logic [AW-1:0] Rw;
  logic [XLEN-1:0] busW;
  logic [AW:0] pending_cnt;
  int checks = 0, failures = 0;

  gpr_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .qa(qa), .qb(qb), .busy_a(busy_a), .busy_b(busy_b),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL reset_regwr got=%b exp=0", RegWr); end
    checks++; if (Rw !== 5'd0) begin failures++; $display("FAIL reset_rw got=%0d exp=0", Rw); end
    checks++; if (busW !== 32'h0) begin failures++; $display("FAIL reset_busw got=%h exp=0", busW); end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 32; r++) begin
      issue_rd = 5'(r); qa = 5'(r); qb = 5'(31 - r);
      #1;
      checks++;
      if (issue_ready !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
        failures++; $display("FAIL idle_rd%0d got ready=%b busy=%b%b exp ready=1 busy=00", r, issue_ready, busy_a, busy_b);
      end
    end
    issue_rd = '0; qa = '0; qb = '0;
  endtask

  task automatic test_alternate;
    step();
    req0_valid = 1; req0_rd = 5'd1; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd2; req1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
        failures++; $display("FAIL alt_grant%0d got r0=%b r1=%b exp r0=%b r1=%b", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
      end
      step();
      checks++;
      if (RegWr !== 1'b1 || Rw !== ((k % 2 == 0) ? 5'd1 : 5'd2) || busW !== ((k % 2 == 0) ? 32'h11 : 32'h22)) begin
        failures++; $display("FAIL alt_write%0d got we=%b rw=%0d busw=%h", k, RegWr, Rw, busW);
      end
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL alt_cnt got=%0d exp=0", pending_cnt); end
  endtask

  task automatic test_raw;
    step();
    issue_valid = 1; issue_rd = 5'd5; qa = 5'd5; qb = 5'd6;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_issue_ready got=%b exp=1", issue_ready); end
    step();
    issue_valid = 0;
    checks++; if (busy_a !== 1'b1 || busy_b !== 1'b0) begin failures++; $display("FAIL raw_busy1 got a=%b b=%b exp a=1 b=0", busy_a, busy_b); end
    checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL raw_cnt1 got=%0d exp=1", pending_cnt); end
    step();
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL raw_r0_ready got=%b exp=1", req0_ready); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL raw_busy_nobypass got=%b exp=1", busy_a); end
    step();
    req0_valid = 0;
    checks++;
    if (RegWr !== 1'b1 || Rw !== 5'd5 || busW !== 32'hDEADBEEF) begin
      failures++; $display("FAIL raw_write got we=%b rw=%0d busw=%h exp we=1 rw=5 busw=deadbeef", RegWr, Rw, busW);
    end
    checks++; if (busy_a !== 1'b0 || pending_cnt !== 6'd0) begin failures++; $display("FAIL raw_clear got busy=%b cnt=%0d exp 0 0", busy_a, pending_cnt); end
    step();
    checks++; if (RegWr !== 1'b0 || Rw !== 5'd5 || busW !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_hold got we=%b rw=%0d busw=%h", RegWr, Rw, busW); end
  endtask

  task automatic test_waw_release;
    issue_valid = 1; issue_rd = 5'd7; qa = 5'd7;
    step();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_block got=%b exp=0", issue_ready); end
    step();
    checks++; if (issue_ready !== 1'b0 || pending_cnt !== 6'd1) begin failures++; $display("FAIL waw_hold got ready=%b cnt=%0d exp 0 1", issue_ready, pending_cnt); end
    req1_valid = 1; req1_rd = 5'd7; req1_data = 32'h77;
    #1;
    checks++; if (req1_ready !== 1'b1 || issue_ready !== 1'b1) begin failures++; $display("FAIL waw_release got r1=%b ready=%b exp 1 1", req1_ready, issue_ready); end
    step();
    req1_valid = 0; issue_valid = 0;
    checks++; if (pending_cnt !== 6'd1 || busy_a !== 1'b1) begin failures++; $display("FAIL waw_kept got cnt=%0d busy=%b exp 1 1", pending_cnt, busy_a); end
    checks++; if (RegWr !== 1'b1 || Rw !== 5'd7 || busW !== 32'h77) begin failures++; $display("FAIL waw_write got we=%b rw=%0d busw=%h", RegWr, Rw, busW); end
    req0_valid = 1; req0_rd = 5'd7; req0_data = 32'h70;
    step();
    req0_valid = 0;
    checks++; if (pending_cnt !== 6'd0 || busy_a !== 1'b0) begin failures++; $display("FAIL waw_drain got cnt=%0d busy=%b exp 0 0", pending_cnt, busy_a); end
  endtask

  task automatic test_x0;
    issue_valid = 1; issue_rd = 5'd4; qa = 5'd0; qb = 5'd4;
    step();
    issue_valid = 0;
    req0_valid = 1; req0_rd = 5'd0; req0_data = 32'hFFFFFFFF;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", req0_ready); end
    step();
    req0_valid = 0;
    checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL x0_regwr got=%b exp=0", RegWr); end
    checks++; if (pending_cnt !== 6'd1 || busy_b !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL x0_sb got cnt=%0d a=%b b=%b exp 1 0 1", pending_cnt, busy_a, busy_b); end
    issue_valid = 1; issue_rd = 5'd0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL x0_issue got=%b exp=1", issue_ready); end
    step();
    issue_valid = 0;
    checks++; if (pending_cnt !== 6'd1 || busy_a !== 1'b0) begin failures++; $display("FAIL x0_issue_cnt got cnt=%0d a=%b exp 1 0", pending_cnt, busy_a); end
    req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h44;
    step();
    req1_valid = 0;
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL x0_drain got=%0d exp=0", pending_cnt); end
  endtask

  task automatic test_reset_mid;
    issue_valid = 1; issue_rd = 5'd3; qa = 5'd3; qb = 5'd9;
    step();
    issue_rd = 5'd9;
    step();
    issue_valid = 0;
    checks++; if (pending_cnt !== 6'd2 || busy_a !== 1'b1 || busy_b !== 1'b1) begin failures++; $display("FAIL mid_pend got cnt=%0d a=%b b=%b exp 2 1 1", pending_cnt, busy_a, busy_b); end
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h33;
    step();
    req0_valid = 0;
    checks++; if (RegWr !== 1'b1 || Rw !== 5'd3) begin failures++; $display("FAIL mid_write got we=%b rw=%0d exp 1 3", RegWr, Rw); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'h0) begin failures++; $display("FAIL mid_rst_wr got we=%b rw=%0d busw=%h exp 0 0 0", RegWr, Rw, busW); end
    checks++; if (pending_cnt !== 6'd0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL mid_rst_sb got cnt=%0d a=%b b=%b exp 0 0 0", pending_cnt, busy_a, busy_b); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h3A;
    req1_valid = 1; req1_rd = 5'd9; req1_data = 32'h9A;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_first_grant got r0=%b r1=%b exp 1 0", req0_ready, req1_ready); end
    step();
    req0_valid = 0;
    #1;
    checks++; if (RegWr !== 1'b1 || Rw !== 5'd3 || busW !== 32'h3A || req1_ready !== 1'b1) begin failures++; $display("FAIL mid_after got we=%b rw=%0d busw=%h r1=%b", RegWr, Rw, busW, req1_ready); end
    step();
    req1_valid = 0;
    checks++; if (RegWr !== 1'b1 || Rw !== 5'd9 || busW !== 32'h9A) begin failures++; $display("FAIL mid_second got we=%b rw=%0d busw=%h exp 1 9 9a", RegWr, Rw, busW); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_raw();
    test_waw_release();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port (RegWr/Rw/busW) between two writeback requesters: req0 is the EXU (ALU/CSR) and req1 is the LSU (load data).
- Holds a per-register pending scoreboard. Decode uses it to detect RAW hazards and stall WAW issue.
- Sits between the execute/memory stages and the register file. Its outputs connect directly to the register file's write port.

Parameters:
- XLEN, 32, data width of busW and requester data.
- AW, 5, register index width; the block tracks 2**AW registers.

Ports:
- clk  in  1  single clock; the register file's WrClk is tied to the same net.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  EXU writeback valid.
- req0_ready  out  1  EXU writeback accepted this cycle.
- req0_rd  in  AW  EXU destination register.
- req0_data  in  XLEN  EXU result.
- req1_valid, req1_ready, req1_rd, req1_data  same as req0, for the LSU.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  issue is accepted this cycle.
- qa  in  AW  hazard query index A (source rs1).
- qb  in  AW  hazard query index B (source rs2).
- busy_a  out  1  qa has an outstanding write.
- busy_b  out  1  qb has an outstanding write.
- RegWr  out  1  register-file write enable.
- Rw  out  AW  register-file write index.
- busW  out  XLEN  register-file write data.
- pending_cnt  out  AW+1  number of set pending bits.

Behaviour:
- Reset (async assert, sync release):
  - RegWr=0, Rw=0, busW=0.
  - All pending bits are 0; pending_cnt=0.
  - last_grant=1, so req0 wins the first contention.
- Grant (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not equal to last_grant wins; the loser sees ready=0 and must hold valid, rd and data stable.
  - last_grant updates only on an accepted transfer.
  - ready is never asserted without the matching valid.
- Write stage (registered): on acceptance at edge N, RegWr=1 with Rw and busW set to the winner's rd/data during cycle N+1. With no acceptance, RegWr=0 and Rw/busW hold their last values. Latency is exactly 1 cycle. Back-to-back acceptances give one write per cycle.
- x0 writes: a request with rd=0 is accepted normally (ready, arbitration) but produces RegWr=0 and touches no pending bit.
- Scoreboard:
  - pending[r] is set at the edge where issue_valid && issue_ready && issue_rd!=0.
  - pending[r] is cleared at the edge where a write to r is accepted; the clear happens at acceptance, not at RegWr.
  - Set and clear of the same r in the same cycle: the bit stays set (the newer issue wins).
  - Accepted write to a non-pending r: the GPR write still happens and the scoreboard is unchanged.
  - pending[0] is always 0.
- issue_ready:
  - 1 when issue_rd==0.
  - Otherwise 1 when !pending[issue_rd], or when pending[issue_rd] is being cleared this cycle (same-cycle release).
  - issue_ready does not depend on issue_valid.
- busy_a = pending[qa]; busy_b = pending[qb]. Both are combinational from the registered bits, with no bypass of same-cycle clears. qa/qb of 0 always give 0.
- pending_cnt: a registered population count, updated in the same edge as the pending bits.
- Reset mid-operation: in-flight writes are dropped (RegWr falls immediately on rst_n low) and all pending bits clear. Requesters must re-present requests after reset.

Test Plan:
- Reset then idle -> RegWr=0, busy_a=busy_b=0, pending_cnt=0, issue_ready=1 for any rd.
- Issue rd=5; after 2 cycles req0 writes rd=5, data=0xDEADBEEF -> busy_a(qa=5)=1 until the accept edge; next cycle RegWr=1, Rw=5, busW=0xDEADBEEF, pending_cnt back to 0.
- Both requesters valid for 4 cycles, req0 rd=1/0x11 and req1 rd=2/0x22 (same values each cycle) -> grants in order req0, req1, req0, req1; RegWr=1 on 4 consecutive cycles, alternating Rw 1,2,1,2.
- Issue rd=7 while pending[7]=1 -> issue_ready=0. Same cycle as the req1 rd=7 accept -> issue_ready=1 and pending[7] stays 1 after the edge.
- req0 writes rd=0, data=0xFFFFFFFF -> req0_ready=1, RegWr stays 0 next cycle, scoreboard unchanged. Issue rd=0 -> accepted, pending_cnt unchanged.
- Pending set on r3 and r9, with a write accepted; assert rst_n=0 asynchronously mid-cycle -> RegWr=0 immediately, pending_cnt=0; after release req0 wins first contention.
